// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared types and defaults for the posted-write store buffer.
//   - SB_DEPTH / SB_ADDR_W / SB_DATA_W : default geometry
//   - sbEntry_t   : one queued store {addr, data}
//   - portOwner_e : who drives the data-memory port in a given cycle
//   Optional feature macro (used by store_buffer): SB_FORWARD_EN
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  // Entries are stored at the package widths; narrower instance widths are
  // zero-extended on the way in and truncated on the way out.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sbEntry_t;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_LOAD  = 2'd1,
    OWN_DRAIN = 2'd2
  } portOwner_e;

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo
//   Circular store queue with head/tail/count and a parallel address search.
//   Ports:
//     clk_i, rst_i            clock, synchronous active-low reset
//     push, pushAddr/Data     enqueue at tail (caller guarantees !full)
//     pop                     dequeue head (caller guarantees !empty)
//     full, empty             occupancy flags derived from the count register
//     headAddr, headData      oldest entry, next to drain
//     searchAddr              load address to look up
//     hit, hitData            any valid entry matches / data of youngest match
//   FWD_EN=0 removes the data mux; hitData then reads as zero.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] headAddr,
  output logic [DATA_W-1:0] headData,
  input  logic [ADDR_W-1:0] searchAddr,
  output logic              hit,
  output logic [DATA_W-1:0] hitData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sbEntry_t           entries [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   scanIdx;
  logic [DEPTH-1:0]   match;
  logic [DATA_W-1:0]  scanData;

  // Pointers are exactly PTR_W bits, so DEPTH being a power of two makes the
  // increment wrap modulo DEPTH for free.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{addr: SB_ADDR_W'(pushAddr), data: SB_DATA_W'(pushData)};
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign headAddr = ADDR_W'(entries[head].addr);
  assign headData = DATA_W'(entries[head].data);

  // Scan from oldest (head) to youngest (tail-1); a later match overwrites an
  // earlier one, so the surviving data is from the youngest matching store.
  always_comb begin
    match    = '0;
    scanData = '0;
    scanIdx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entries[scanIdx].addr == SB_ADDR_W'(searchAddr))) begin
        match[k] = 1'b1;
        scanData = DATA_W'(entries[scanIdx].data);
      end
    end
  end

  assign hit = |match;

  generate
    if (FWD_EN) begin : gFwd
      assign hitData = scanData;
    end else begin : gNoFwd
      assign hitData = '0;
    end
  endgenerate

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write buffer between the MEM stage and the data memory. Stores are
//   queued and drained one per free memory cycle; loads bypass the queue.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-low reset
//     req_valid_i/write/addr/wdata MEM stage request (write=1 store, 0 load)
//     req_ready_o                  request accepted this cycle
//     rsp_valid_o, rsp_rdata_o     load data, one cycle after acceptance
//     sb_empty_o                   no queued stores
//     mem_addr_o/wdata_o/write_o/read_o, mem_rdata_i   data-memory port
//   Macro SB_FORWARD_EN: when defined, load hits are served from the youngest
//   matching queued store. When undefined, a hitting load stalls until the
//   matching stores have drained, then reads memory.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              sb_empty_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

`ifdef SB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              isLoad, isStore;
  logic              full, empty, hit;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData, hitData;
  logic              loadAccept, loadMiss, storeAccept;
  portOwner_e        owner;

  assign isLoad  = req_valid_i & ~req_write_i;
  assign isStore = req_valid_i &  req_write_i;

`ifdef SB_FORWARD_EN
  // Loads are never blocked; only a miss needs the memory port.
  assign loadAccept = isLoad;
  assign loadMiss   = isLoad & ~hit;
`else
  // A hitting load waits for the matching stores to drain, then misses.
  assign loadAccept = isLoad & ~hit;
  assign loadMiss   = loadAccept;
`endif

  // Full is judged on the current count: a same-cycle drain does not free a slot.
  assign storeAccept = isStore & ~full;
  assign req_ready_o = storeAccept | loadAccept;
  assign sb_empty_o  = empty;

  sb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .FWD_EN (FWD_EN)
  ) uFifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (storeAccept),
    .pushAddr   (req_addr_i),
    .pushData   (req_wdata_i),
    .pop        (owner == OWN_DRAIN),
    .full       (full),
    .empty      (empty),
    .headAddr   (headAddr),
    .headData   (headData),
    .searchAddr (req_addr_i),
    .hit        (hit),
    .hitData    (hitData)
  );

  // A missing load takes priority over draining so the pipeline never waits.
  always_comb begin
    owner = OWN_IDLE;
    if (loadMiss)    owner = OWN_LOAD;
    else if (!empty) owner = OWN_DRAIN;
  end

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (owner)
      OWN_LOAD: begin
        mem_read_o = 1'b1;
        mem_addr_o = req_addr_i;
      end
      OWN_DRAIN: begin
        mem_write_o = 1'b1;
        mem_addr_o  = headAddr;
        mem_wdata_o = headData;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= loadAccept;
      if (loadAccept) rsp_rdata_o <= (FWD_EN && hit) ? hitData : mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_write_i = 1'b0;
  logic [AW-1:0] req_addr_i  = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          req_ready_o, rsp_valid_o, sb_empty_o, mem_write_o, mem_read_o;
  logic [DW-1:0] rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] mem_addr_o;

  store_buffer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .sb_empty_o  (sb_empty_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] initVal(input int i);
    return (i == 2) ? 32'h55 : 32'h100 + i;
  endfunction

  // Data memory attached to the DUT (8 words, address low bits).
  logic [DW-1:0] dutMem [8];
  logic          memLoad;
  assign mem_rdata_i = dutMem[mem_addr_o[2:0]];
  always @(posedge clk_i) begin
    if (memLoad) for (int i = 0; i < 8; i++) dutMem[i] <= initVal(i);
    else if (mem_write_o && rst_i) dutMem[mem_addr_o[2:0]] <= mem_wdata_o;
  end
  initial begin
    memLoad = 1'b1;
    @(posedge clk_i);
    #1 memLoad = 1'b0;
  end

  // Reference model: program-order queue of pending stores plus memory image.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;
  ent_t          q[$];
  logic [DW-1:0] refMem [8];
  bit            pendValid;
  logic [DW-1:0] pendData;
  int            passCnt = 0;
  int            totCnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: drive request, check outputs mid-cycle, advance the model.
  task automatic step(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit            full, hit, expReady, expRd, expWr;
    logic [DW-1:0] yData;
    logic [AW-1:0] expAddr;
    ent_t          old;
    req_valid_i = v;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    #4;
    full  = (q.size() == DEPTH);
    hit   = 1'b0;
    yData = '0;
    foreach (q[i]) if (q[i].addr == a) begin hit = 1'b1; yData = q[i].data; end
    expRd    = v && !w && !hit;
    expWr    = !expRd && (q.size() > 0);
    expReady = v && (w ? !full : (FWD || !hit));
    expAddr  = expRd ? a : (expWr ? q[0].addr : '0);
    check("req_ready", req_ready_o, expReady);
    check("mem_read", mem_read_o, expRd);
    check("mem_write", mem_write_o, expWr);
    check("mem_addr", mem_addr_o, expAddr);
    if (expWr) check("mem_wdata", mem_wdata_o, q[0].data);
    check("rsp_valid", rsp_valid_o, pendValid);
    if (pendValid) check("rsp_rdata", rsp_rdata_o, pendData);
    check("sb_empty", sb_empty_o, q.size() == 0);
    pendValid = v && !w && expReady;
    if (pendValid) pendData = hit ? yData : refMem[a[2:0]];
    if (expWr) begin
      old = q.pop_front();
      refMem[old.addr[2:0]] = old.data;
    end
    if (v && w && !full) q.push_back('{addr: a, data: d});
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset(input int n);
    rst_i       = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h7;
    req_wdata_i = 32'hDEAD;
    repeat (n) @(posedge clk_i);
    #1;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    q.delete();
    pendValid = 1'b0;
    pendData  = '0;
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check("rst_sb_empty", sb_empty_o, 1'b1);
    check("rst_mem_write", mem_write_o, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) refMem[i] = initVal(i);
    pendValid = 1'b0;
    pendData  = '0;

    // Reset held two cycles with a request pending.
    doReset(2);

    // Single store drains on the next idle cycle.
    step(1, 1, 3, 32'h11);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Stores interleaved with load misses, then one more store and idles.
    step(1, 1, 0, 32'h201);
    step(1, 0, 6, 0);
    step(1, 1, 1, 32'h202);
    step(1, 0, 7, 0);
    step(1, 1, 4, 32'h203);
    step(1, 0, 6, 0);
    step(1, 1, 5, 32'h204);
    step(1, 1, 3, 32'h205);
    repeat (3) step(0, 0, 0, 0);

    // Two stores to one address, then a load of it (forwarded or stalled).
    step(1, 1, 5, 32'hAA);
    step(1, 1, 5, 32'hBB);
    repeat (3) step(1, 0, 5, 0);
    repeat (2) step(0, 0, 0, 0);

    // Load miss to address 2 with stores queued ahead of it.
    step(1, 1, 0, 32'h301);
    step(1, 1, 1, 32'h302);
    step(1, 0, 2, 0);
    repeat (3) step(0, 0, 0, 0);

    // Reset with stores pending; nothing more may drain.
    step(1, 1, 4, 32'h401);
    step(1, 1, 6, 32'h402);
    step(1, 1, 7, 32'h403);
    doReset(1);
    repeat (2) step(0, 0, 0, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) doReset(1);
      else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 7)), DW'($urandom));
    end
    repeat (4) step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
